// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
// Decode-to-execute stage sitting behind the register file. Drives the read
// addresses, forwards same-cycle writeback data, tracks in-flight destination
// writes in a pending scoreboard and stalls on RAW/WAW hazards. The captured
// operands are presented through a registered valid/ready output.
//
// Optional feature macro: ZERO_REG_EN
//   defined   -> register 0 reads as zero, is never marked pending and never
//                causes a hazard.
//   undefined -> register 0 is an ordinary register.
module operand_fetch_stage #(
    parameter int D = 5,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [D-1:0] in_rs1,
    input  logic [D-1:0] in_rs2,
    input  logic [D-1:0] in_rd,
    input  logic         in_reg_write,
    output logic [D-1:0] rf_address1,
    output logic [D-1:0] rf_address2,
    input  logic [W-1:0] rf_read_data1,
    input  logic [W-1:0] rf_read_data2,
    input  logic         wb_valid,
    input  logic [D-1:0] wb_rd,
    input  logic [W-1:0] wb_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_op1,
    output logic [W-1:0] out_op2,
    output logic [D-1:0] out_rd,
    output logic         out_reg_write
);

    localparam int NREG = 1 << D;

`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_next;
    logic [NREG-1:0] wb_mask;
    logic [NREG-1:0] eff_pending;
    logic            hazard;
    logic            accept;
    logic            set_pending;
    logic [W-1:0]    op1_sel;
    logic [W-1:0]    op2_sel;

    // Register 0 is hardwired only when the zero-register feature is built in.
    function automatic logic is_zero(input logic [D-1:0] r);
        return ZERO_REG && (r == '0);
    endfunction

    // A held, still-unretired output that will write register r.
    function automatic logic held_writes(input logic [D-1:0] r);
        return out_valid && out_reg_write && !is_zero(out_rd) && (out_rd == r);
    endfunction

    // Operand source: zero register, then same-cycle writeback, then register file.
    function automatic logic [W-1:0] pick_operand(input logic [D-1:0] r,
                                                  input logic [W-1:0] rf_data);
        if (is_zero(r)) begin
            return '0;
        end else if (wb_valid && (wb_rd == r)) begin
            return wb_data;
        end else begin
            return rf_data;
        end
    endfunction

    assign rf_address1 = in_rs1;
    assign rf_address2 = in_rs2;

    // Writeback-first view of the scoreboard for this cycle's hazard check.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        wb_mask = '0;
        if (wb_valid) begin
            wb_mask[wb_rd] = 1'b1;
        end
        eff_pending = pending & ~wb_mask;
    end

    // RAW/WAW hazard against the scoreboard and against the held output.
    always_comb begin
        hazard = 1'b0;
        if (in_valid) begin
            if ((eff_pending[in_rs1] && !is_zero(in_rs1)) ||
                (eff_pending[in_rs2] && !is_zero(in_rs2)) ||
                (in_reg_write && eff_pending[in_rd] && !is_zero(in_rd))) begin
                hazard = 1'b1;
            end
            if (held_writes(in_rs1) || held_writes(in_rs2) ||
                (in_reg_write && held_writes(in_rd))) begin
                hazard = 1'b1;
            end
        end
    end

    assign in_ready = !hazard && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign op1_sel  = pick_operand(in_rs1, rf_read_data1);
    assign op2_sel  = pick_operand(in_rs2, rf_read_data2);

    // A retiring output that writes a register becomes pending; a flushed one never does.
    assign set_pending = out_valid && out_ready && !flush && out_reg_write && !is_zero(out_rd);

    // Scoreboard update: writeback clears, retiring output sets, set wins on a tie.
    always_comb begin
        pending_next = pending & ~wb_mask;
        if (set_pending) begin
            pending_next[out_rd] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the pending bits are a flop vector, so they are reset like any other state;
        // an unreset scoreboard would stall or race from power-up.
        if (!rst_n) begin
            pending <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            pending <= pending_next;
        end
    end

    // ID/EX output register: flush kills, accept loads, consume without accept empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_op1       <= '0;
            out_op2       <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_op1       <= op1_sel;
            out_op2       <= op2_sel;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
